ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the same open-drain PS2_KBCLK/PS2_KBDAT pair the keyboard receiver listens on. It performs the request-to-send clock inhibit, shifts out start, 8 data bits LSB-first, odd parity and stop on device-generated clock edges, and checks the device's line-ack. oBUSY gates the receiver's enable so the receiver does not capture the host's own frame.

## Interface
- RTS_CYC, 5000: iCLK_50 cycles the clock line is held low before the start bit (100 µs).
- REQ_CYC, 50: cycles the clock line stays low after data is pulled low (1 µs).
- TMO_CYC, 750000: cycles without a filtered falling edge (or idle-bus return) before abort (15 ms).

- iCLK_50  input  1  system clock, 50 MHz.
- iKEY  input  1  asynchronous active-low reset.
- iWR  input  1  start strobe; sampled only in IDLE.
- iDATA  input  8  byte to send; captured on accepted iWR.
- PS2_KBCLK  input  1  PS/2 clock pin level (pad input).
- PS2_KBDAT  input  1  PS/2 data pin level (pad input).
- oPS2C_OE  output  1  1 = drive clock pad low; 0 = release (pull-up).
- oPS2D_OE  output  1  1 = drive data pad low; 0 = release.
- oBUSY  output  1  high from accepted iWR until oDONE.
- oDONE  output  1  one-cycle pulse at end of every transaction.
- oERR  output  1  one-cycle pulse, coincident with oDONE, on timeout or missing ack.

## Operation
- Clock input: 2-flop synchronizer, then 8-sample shift filter; filtered level changes only when all 8 samples agree. fall = filtered 1->0, one-cycle tick. Data pin sampled through a 2-flop synchronizer.
- Shift register 9 bits = {odd parity (~^iDATA), iDATA}, loaded on accepted iWR. Bit counter 4 bits. Timer 20 bits (covers TMO_CYC).
- States:
  - IDLE: OEs 0, oBUSY 0. iWR=1 -> load shifter, timer=0, go RTS.
  - RTS: oPS2C_OE=1. After RTS_CYC cycles -> REQ, timer=0.
  - REQ: oPS2C_OE=1, oPS2D_OE=1 (start bit 0). After REQ_CYC cycles -> release clock, go DATA, n=0, timer=0.
  - DATA: on each fall: oPS2D_OE = ~shifter[0], shift right, n++ ; fall number 1..8 -> D0..D7, 9 -> parity; after 9th fall go STOP.
  - STOP: on fall (10th): oPS2D_OE=0 (stop bit 1), go ACK.
  - ACK: on fall (11th): synchronized data = 0 -> ack ok, else nack flag; go WAITIDLE.
  - WAITIDLE: when filtered clock=1 and synchronized data=1 -> oDONE (oERR = nack flag), go IDLE.
- Timer resets on every fall in DATA/STOP/ACK; in DATA/STOP/ACK/WAITIDLE reaching TMO_CYC: release both lines, pulse oDONE+oERR, go IDLE.
- iWR outside IDLE ignored; iDATA changes after acceptance have no effect.
- Reset (any state, including mid-frame): immediately state IDLE, oPS2C_OE=0, oPS2D_OE=0, oBUSY=0, oDONE=0, oERR=0, filter/synchronizers cleared to 1 (idle bus), counters 0.

## Timing
- All outputs registered. iWR high at edge t -> oBUSY and oPS2C_OE high after edge t+1.
- oPS2D_OE asserts exactly RTS_CYC cycles after oPS2C_OE; oPS2C_OE drops REQ_CYC cycles later.
- Pin falling edge -> fall tick after 2 sync + 8 filter cycles (≤11 cycles); oPS2D_OE updates the cycle after fall, well within the ≥20 µs device low phase.
- oDONE/oERR: single cycle; oBUSY drops in the same cycle oDONE is high.
- Device clock 10-16.7 kHz gives ~1 ms per frame; glitches shorter than 8 cycles never produce fall.

## Test plan
Bench uses a device BFM on wired-AND pads; RTS_CYC=100, REQ_CYC=10, TMO_CYC=2000 for speed.
- Reset mid-DATA (after 4th fall): both OEs 0 within the reset assertion, oBUSY=0, no oDONE; next iWR runs a clean frame.
- iWR with iDATA=0xED, BFM acks: clock low 100 cycles, data low then clock released 10 cycles later; BFM captures start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; oDONE=1, oERR=0.
- iDATA=0x01: BFM sees parity 0; iDATA=0x00 and 0xFF: parity 1; all oERR=0.
- BFM holds data high at 11th clock (no ack): oDONE=1 with oERR=1 after bus idle.
- BFM never clocks after request: 2000 cycles after clock release both OEs 0, oDONE=oERR=1, back in IDLE.
- iWR pulsed again while oBUSY=1 with different iDATA: ignored, first byte transmitted intact; 3-cycle glitch on PS2_KBCLK during DATA produces no extra bit.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: RTS clock inhibit, then start/8 data/parity/stop on device clock, then ack check.
// Latency: clock OE one cycle after accepted iWR; data bit updates one cycle after each filtered device-clock fall.
// Backpressure: iWR accepted only in IDLE (oBUSY low); strobes while busy are dropped.
module ps2_host_tx #(
    parameter int RTS_CYC = 5000,
    parameter int REQ_CYC = 50,
    parameter int TMO_CYC = 750000
) (
    input  logic       iCLK_50,
    input  logic       iKEY,
    input  logic       iWR,
    input  logic [7:0] iDATA,
    input  logic       PS2_KBCLK,
    input  logic       PS2_KBDAT,
    output logic       oPS2C_OE,
    output logic       oPS2D_OE,
    output logic       oBUSY,
    output logic       oDONE,
    output logic       oERR
);

    localparam logic [19:0] RTS_LAST = 20'(RTS_CYC - 1);
    localparam logic [19:0] REQ_LAST = 20'(REQ_CYC - 1);
    localparam logic [19:0] TMO_LAST = 20'(TMO_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RTS,
        S_REQ,
        S_DATA,
        S_STOP,
        S_ACK,
        S_WAITIDLE
    } state_t;

    logic [1:0] clk_sync;
    logic [1:0] dat_sync;
    logic [7:0] clk_hist;
    logic       clk_filt;
    logic       fall;
    logic       dat_s;

    state_t      state;
    logic [8:0]  shifter;
    logic [3:0]  bit_cnt;
    logic [19:0] timer;
    logic        nack;

    assign dat_s = dat_sync[1];

    // Filtered clock only moves when all 8 history samples agree, so short glitches are invisible.
    always_ff @(posedge iCLK_50 or negedge iKEY) begin
        if (!iKEY) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_hist <= 8'hFF;
            clk_filt <= 1'b1;
            fall     <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], PS2_KBCLK};
            dat_sync <= {dat_sync[0], PS2_KBDAT};
            clk_hist <= {clk_hist[6:0], clk_sync[1]};
            fall     <= 1'b0;
            if (clk_hist == 8'hFF) begin
                clk_filt <= 1'b1;
            end else if (clk_hist == 8'h00) begin
                if (clk_filt) begin
                    fall <= 1'b1;
                end
                clk_filt <= 1'b0;
            end
        end
    end

    always_ff @(posedge iCLK_50 or negedge iKEY) begin
        if (!iKEY) begin
            state    <= S_IDLE;
            shifter  <= '0;
            bit_cnt  <= '0;
            timer    <= '0;
            nack     <= 1'b0;
            oPS2C_OE <= 1'b0;
            oPS2D_OE <= 1'b0;
            oBUSY    <= 1'b0;
            oDONE    <= 1'b0;
            oERR     <= 1'b0;
        end else begin
            oDONE <= 1'b0;
            oERR  <= 1'b0;
            case (state)
                S_IDLE: begin
                    oPS2C_OE <= 1'b0;
                    oPS2D_OE <= 1'b0;
                    oBUSY    <= 1'b0;
                    if (iWR) begin
                        shifter  <= {~^iDATA, iDATA};
                        timer    <= '0;
                        oBUSY    <= 1'b1;
                        oPS2C_OE <= 1'b1;
                        state    <= S_RTS;
                    end
                end
                S_RTS: begin
                    if (timer == RTS_LAST) begin
                        timer    <= '0;
                        oPS2D_OE <= 1'b1;
                        state    <= S_REQ;
                    end else begin
                        timer <= timer + 20'd1;
                    end
                end
                S_REQ: begin
                    if (timer == REQ_LAST) begin
                        timer    <= '0;
                        bit_cnt  <= '0;
                        oPS2C_OE <= 1'b0;
                        state    <= S_DATA;
                    end else begin
                        timer <= timer + 20'd1;
                    end
                end
                S_DATA, S_STOP, S_ACK, S_WAITIDLE: begin
                    if (fall && state != S_WAITIDLE) begin
                        timer <= '0;
                        if (state == S_DATA) begin
                            oPS2D_OE <= ~shifter[0];
                            shifter  <= {1'b0, shifter[8:1]};
                            bit_cnt  <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd8) begin
                                state <= S_STOP;
                            end
                        end else if (state == S_STOP) begin
                            oPS2D_OE <= 1'b0;
                            state    <= S_ACK;
                        end else begin
                            nack  <= dat_s;
                            state <= S_WAITIDLE;
                        end
                    end else if (state == S_WAITIDLE && clk_filt && dat_s) begin
                        oDONE <= 1'b1;
                        oERR  <= nack;
                        oBUSY <= 1'b0;
                        state <= S_IDLE;
                    end else if (timer == TMO_LAST) begin
                        // Device stopped clocking or never released the bus: abandon the frame.
                        oPS2C_OE <= 1'b0;
                        oPS2D_OE <= 1'b0;
                        oDONE    <= 1'b1;
                        oERR     <= 1'b1;
                        oBUSY    <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        timer <= timer + 20'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: keyboard BFM on wired-AND pads, frames compared against a byte-level reference.
module tb_ps2_host_tx;

    localparam int RTS = 100;
    localparam int REQ = 10;
    localparam int TMO = 2000;
    localparam int LO  = 40;
    localparam int HI  = 40;

    logic       iCLK_50 = 1'b0;
    logic       iKEY;
    logic       iWR;
    logic [7:0] iDATA;
    logic       PS2_KBCLK;
    logic       PS2_KBDAT;
    logic       c_oe, d_oe, busy, done, err;
    logic       dev_clk_low, dev_dat_low;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [10:0] bfm_cap;
    int          bfm_rts, bfm_req, bfm_rel_cyc;
    logic        done_seen, done_err, done_busy, done_after;
    int          done_cyc;

    assign PS2_KBCLK = ~(c_oe | dev_clk_low);
    assign PS2_KBDAT = ~(d_oe | dev_dat_low);

    ps2_host_tx #(.RTS_CYC(RTS), .REQ_CYC(REQ), .TMO_CYC(TMO)) dut (
        .iCLK_50  (iCLK_50),
        .iKEY     (iKEY),
        .iWR      (iWR),
        .iDATA    (iDATA),
        .PS2_KBCLK(PS2_KBCLK),
        .PS2_KBDAT(PS2_KBDAT),
        .oPS2C_OE (c_oe),
        .oPS2D_OE (d_oe),
        .oBUSY    (busy),
        .oDONE    (done),
        .oERR     (err)
    );

    always #10 iCLK_50 = ~iCLK_50;
    always @(posedge iCLK_50) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge iCLK_50);
    endtask

    // Reference: start 0, data LSB first, parity making the one-count odd, stop 1.
    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = d[i];
            if (d[i]) ones++;
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Keyboard model: samples data late in each clock-high phase, host changes it after falls.
    task automatic dev_frame(input int n_falls, input bit ack, input bit glitch);
        int t;
        bfm_cap = '0;
        bfm_rts = 0;
        bfm_req = 0;
        t = 0;
        while (!c_oe && t < 20) begin
            @(negedge iCLK_50);
            t++;
        end
        while (!d_oe && bfm_rts < 1000) begin
            @(negedge iCLK_50);
            bfm_rts++;
        end
        while (c_oe && bfm_req < 1000) begin
            @(negedge iCLK_50);
            bfm_req++;
        end
        bfm_rel_cyc = cyc;
        wait_cycles(HI);
        bfm_cap[0] = PS2_KBDAT;
        for (int i = 1; i <= n_falls; i++) begin
            if (i == 11 && ack) begin
                dev_dat_low = 1'b1;
                wait_cycles(5);
            end
            dev_clk_low = 1'b1;
            wait_cycles(LO);
            dev_clk_low = 1'b0;
            dev_dat_low = 1'b0;
            if (glitch && i == 3) begin
                wait_cycles(15);
                dev_clk_low = 1'b1;
                wait_cycles(3);
                dev_clk_low = 1'b0;
                wait_cycles(HI - 18);
            end else begin
                wait_cycles(HI);
            end
            if (i <= 10) bfm_cap[i] = PS2_KBDAT;
        end
    endtask

    task automatic watch_done();
        done_seen = 1'b0;
        done_err  = 1'b0;
        done_busy = 1'b1;
        for (int t = 0; t < 6000 && !done_seen; t++) begin
            @(negedge iCLK_50);
            if (done) begin
                done_seen = 1'b1;
                done_err  = err;
                done_busy = busy;
                done_cyc  = cyc;
            end
        end
        @(negedge iCLK_50);
        done_after = done;
    endtask

    task automatic start_wr(input logic [7:0] d);
        @(negedge iCLK_50);
        iDATA = d;
        iWR   = 1'b1;
        @(negedge iCLK_50);
        iWR   = 1'b0;
    endtask

    task automatic run_txn(input logic [7:0] d, input bit ack, input bit glitch, input bit dbl,
                           input bit timing);
        start_wr(d);
        chk("busy_on_wr", busy, 1);
        chk("clk_oe_on_wr", c_oe, 1);
        fork
            dev_frame(11, ack, glitch);
            watch_done();
            if (dbl) begin
                wait_cycles(300);
                iDATA = ~d;
                iWR   = 1'b1;
                @(negedge iCLK_50);
                iWR   = 1'b0;
            end
        join
        if (timing) begin
            chk("rts_len", bfm_rts, RTS);
            chk("req_len", bfm_req, REQ);
        end
        chk("frame", bfm_cap, exp_frame(d));
        chk("done_seen", done_seen, 1);
        chk("done_err", done_err, !ack);
        chk("busy_at_done", done_busy, 0);
        chk("done_one_cycle", done_after, 0);
        wait_cycles(20);
    endtask

    initial begin
        logic [7:0] rd;
        iKEY = 1'b0;
        iWR = 1'b0;
        iDATA = 8'h00;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        wait_cycles(3);
        chk("rst_outputs", {c_oe, d_oe, busy, done, err}, 5'b0);
        iKEY = 1'b1;
        wait_cycles(20);

        run_txn(8'hED, 1, 0, 0, 1);
        run_txn(8'h01, 1, 0, 0, 0);
        run_txn(8'h00, 1, 0, 0, 0);
        run_txn(8'hFF, 1, 0, 0, 0);
        run_txn(8'($urandom), 0, 0, 0, 0);
        run_txn(8'h3C, 1, 1, 1, 0);

        // Device never clocks after the request.
        start_wr(8'hA5);
        fork
            dev_frame(0, 0, 0);
            watch_done();
        join
        chk("tmo_done", done_seen, 1);
        chk("tmo_err", done_err, 1);
        chk("tmo_window", (done_cyc - bfm_rel_cyc >= TMO - 1) && (done_cyc - bfm_rel_cyc <= TMO + 1), 1);
        chk("tmo_released", {c_oe, d_oe, busy}, 3'b0);
        wait_cycles(20);

        // Reset after the 4th fall; 0x52 has D3=0 so data is being driven low at that point.
        start_wr(8'h52);
        dev_frame(4, 0, 0);
        chk("pre_rst_d_oe", d_oe, 1);
        @(negedge iCLK_50);
        iKEY = 1'b0;
        #1;
        chk("midrst_outputs", {c_oe, d_oe, busy, done, err}, 5'b0);
        wait_cycles(5);
        chk("midrst_hold", {c_oe, d_oe, busy, done}, 4'b0);
        iKEY = 1'b1;
        wait_cycles(30);
        chk("post_rst_idle", {c_oe, d_oe, busy, done}, 4'b0);
        run_txn(8'h96, 1, 0, 0, 0);

        for (int k = 0; k < 6; k++) begin
            rd = 8'($urandom);
            run_txn(rd, ($urandom_range(0, 3) != 0), 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
